// File: rtl/sram_ctrl.sv
// sram_ctrl -- single-port asynchronous SRAM controller.
//
// Accepts one read or write request at a time from a simple cs/r/w handshake,
// runs the external SRAM strobes for a fixed number of wait cycles, and
// returns a one-cycle ready pulse. Every output is a flop, so the external
// strobes are glitch-free and reset takes effect as soon as nreset falls.
//
// Optional feature macro: SRAM_CTRL_TURNAROUND_EN
//   When defined, a write that follows a completed read gets one idle bus
//   cycle (state TURN) before its strobes go active, which stops the SRAM's
//   output drivers and the controller's drivers from overlapping.
//
// Ports:
//   clk, nreset          clock and asynchronous active-low reset
//   cs, r, w, addr,      request: cs held until ready; r = read;
//   dwrite               w = per-byte write enables; word address; write data
//   rdata                data captured from the last completed read
//   ready                one-cycle completion pulse
//   busy                 high while an access is in progress
//   sram_dq              bidirectional SRAM data bus
//   sram_addr            registered SRAM address
//   sram_ce_n/oe_n/we_n  active-low chip enable, output enable, write enable
//   sram_be_n            active-low byte lane enables
//
// States:
//   IDLE   | waiting for a request
//   TURN   | bus turnaround before a write that follows a read (macro only)
//   ACCESS | strobes active for WAIT+1 cycles
//   DONE   | ready pulse; write data still held on the bus

module sram_ctrl #(
  parameter int DW      = 16,
  parameter int AW      = 18,
  parameter int RD_WAIT = 3,
  parameter int WR_WAIT = 3
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            cs,
  input  logic            r,
  input  logic [DW/8-1:0] w,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   dwrite,
  output logic [DW-1:0]   rdata,
  output logic            ready,
  output logic            busy,
  inout  wire  [DW-1:0]   sram_dq,
  output logic [AW-1:0]   sram_addr,
  output logic            sram_ce_n,
  output logic            sram_oe_n,
  output logic            sram_we_n,
  output logic [DW/8-1:0] sram_be_n
);

  localparam int NBE = DW / 8;
  localparam logic [2:0] RD_CNT = 3'(RD_WAIT);
  localparam logic [2:0] WR_CNT = 3'(WR_WAIT);

`ifdef SRAM_CTRL_TURNAROUND_EN
  typedef enum logic [1:0] {IDLE, TURN, ACCESS, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
`endif

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           rd_q, rd_d;
  logic [NBE-1:0] wen_q, wen_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           ce_n_q, ce_n_d;
  logic           oe_n_q, oe_n_d;
  logic           we_n_q, we_n_d;
  logic [NBE-1:0] be_n_q, be_n_d;
  logic           dq_oe_q, dq_oe_d;
`ifdef SRAM_CTRL_TURNAROUND_EN
  logic           last_rd_q, last_rd_d;
`endif

  logic accept;
  assign accept = cs & (r | (|w));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef SRAM_CTRL_TURNAROUND_EN
    last_rd_d = last_rd_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          // Read wins when both r and a write enable are set.
          rd_d    = r;
          wen_d   = w;
          addr_d  = addr;
          wdata_d = dwrite;
          cnt_d   = r ? RD_CNT : WR_CNT;
          state_d = ACCESS;
`ifdef SRAM_CTRL_TURNAROUND_EN
          if (!r && last_rd_q) state_d = TURN;
`endif
        end
      end
`ifdef SRAM_CTRL_TURNAROUND_EN
      TURN: state_d = ACCESS;
`endif
      ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d = DONE;
          if (rd_q) rdata_d = sram_dq;
`ifdef SRAM_CTRL_TURNAROUND_EN
          last_rd_d = rd_q;
`endif
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered
    // and line up with the state they belong to.
    ready_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    ce_n_d  = (state_d != ACCESS);
    oe_n_d  = !((state_d == ACCESS) && rd_d);
    we_n_d  = !((state_d == ACCESS) && !rd_d);
    be_n_d  = (state_d == ACCESS) ? (rd_d ? '0 : ~wen_d) : '1;
    // Write data stays on the bus through DONE for SRAM hold time.
    dq_oe_d = ((state_d == ACCESS) || (state_d == DONE)) && !rd_d;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      rd_q      <= 1'b0;
      wen_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      be_n_q    <= '1;
      dq_oe_q   <= 1'b0;
`ifdef SRAM_CTRL_TURNAROUND_EN
      last_rd_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      be_n_q    <= be_n_d;
      dq_oe_q   <= dq_oe_d;
`ifdef SRAM_CTRL_TURNAROUND_EN
      last_rd_q <= last_rd_d;
`endif
    end
  end

  assign rdata     = rdata_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_be_n = be_n_q;
  assign sram_dq   = dq_oe_q ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl: a small SRAM model on the external bus, a table of
// directed accesses with hand-computed results, and hand-written sequences
// for reset-during-access and cs dropped mid-access.

module tb_sram_ctrl;
  localparam int DW = 16;
  localparam int AW = 18;
  localparam int NBE = 2;
`ifdef SRAM_CTRL_TURNAROUND_EN
  localparam int TURN_EXTRA = 1;
`else
  localparam int TURN_EXTRA = 0;
`endif

  logic           clk = 1'b0;
  logic           nreset;
  logic           cs, r;
  logic [NBE-1:0] w;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  dwrite;
  logic [DW-1:0]  rdata;
  logic           ready, busy;
  wire  [DW-1:0]  sram_dq;
  logic [AW-1:0]  sram_addr;
  logic           sram_ce_n, sram_oe_n, sram_we_n;
  logic [NBE-1:0] sram_be_n;

  logic [DW-1:0]  mem [16];
  int n_cmp = 0;
  int n_bad = 0;
  logic last_rd = 1'b0;

  always #5 clk = ~clk;

  sram_ctrl #(.DW(DW), .AW(AW), .RD_WAIT(3), .WR_WAIT(0)) dut (
    .clk(clk), .nreset(nreset), .cs(cs), .r(r), .w(w), .addr(addr),
    .dwrite(dwrite), .rdata(rdata), .ready(ready), .busy(busy),
    .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  // SRAM model: 16 words indexed by the low address bits.
  assign sram_dq = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[3:0]] : {DW{1'bz}};

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[3]  <= 16'hBEEF;
      mem[5]  <= 16'h1234;
      mem[15] <= 16'hCAFE;
    end else if (!sram_ce_n && !sram_we_n) begin
      for (int i = 0; i < NBE; i++)
        if (!sram_be_n[i]) mem[sram_addr[3:0]][8*i +: 8] <= sram_dq[8*i +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic           rd;
    logic [NBE-1:0] wen;
    logic [AW-1:0]  a;
    logic [DW-1:0]  d;
    int             lat;
    int             ce_cyc;
    int             we_cyc;
    logic [NBE-1:0] be;
    logic [DW-1:0]  rdat;
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v, input int idx);
    int lat, ce_c, oe_c, we_c, dq_c, exp_lat;
    logic [NBE-1:0] be_seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    exp_lat = v.lat + ((!v.rd && last_rd) ? TURN_EXTRA : 0);
    lat = -1; ce_c = 0; oe_c = 0; we_c = 0; dq_c = 0; be_seen = '1;
    @(posedge clk); #1;
    cs = 1'b1; r = v.rd; w = v.wen; addr = v.a; dwrite = v.d;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, " busy"}, 32'(busy), 32'd1);
      if (!sram_ce_n) begin
        ce_c++;
        be_seen = sram_be_n;
      end
      if (!sram_oe_n) oe_c++;
      if (!sram_we_n) we_c++;
      if (!v.rd && sram_dq == v.d) dq_c++;
      if (ready) begin
        lat = k;
        chk({tag, " sram_addr"}, 32'(sram_addr), 32'(v.a));
        cs = 1'b0; r = 1'b0; w = '0;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    if (!v.rd && sram_dq == v.d) dq_c++;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " ce cycles"}, 32'(ce_c), 32'(v.ce_cyc));
    chk({tag, " oe cycles"}, 32'(oe_c), v.rd ? 32'(v.ce_cyc) : 32'd0);
    chk({tag, " we cycles"}, 32'(we_c), 32'(v.we_cyc));
    chk({tag, " be_n"}, 32'(be_seen), 32'(v.be));
    if (!v.rd) chk({tag, " dq drive cycles"}, 32'(dq_c), 32'd2);
    chk({tag, " rdata"}, 32'(rdata), 32'(v.rdat));
    chk({tag, " busy after"}, 32'(busy), 32'd0);
    chk({tag, " ready after"}, 32'(ready), 32'd0);
    last_rd = v.rd;
  endtask

  initial begin
    int lat, seen;
    vecs[0] = '{1'b1, 2'b00, 18'h00123, 16'h0000, 5, 4, 0, 2'b00, 16'hBEEF};
    vecs[1] = '{1'b0, 2'b01, 18'h00005, 16'h55AA, 2, 1, 1, 2'b10, 16'hBEEF};
    vecs[2] = '{1'b1, 2'b00, 18'h00005, 16'h0000, 5, 4, 0, 2'b00, 16'h12AA};
    vecs[3] = '{1'b1, 2'b11, 18'h3FFFF, 16'hDEAD, 5, 4, 0, 2'b00, 16'hCAFE};
    vecs[4] = '{1'b0, 2'b10, 18'h3FFFF, 16'hAB00, 2, 1, 1, 2'b01, 16'hCAFE};
    vecs[5] = '{1'b0, 2'b11, 18'h00007, 16'h0F0F, 2, 1, 1, 2'b00, 16'hCAFE};
    vecs[6] = '{1'b1, 2'b00, 18'h00007, 16'h0000, 5, 4, 0, 2'b00, 16'h0F0F};
    vecs[7] = '{1'b1, 2'b00, 18'h3FFFF, 16'h0000, 5, 4, 0, 2'b00, 16'hABFE};

    cs = 1'b0; r = 1'b0; w = '0; addr = '0; dwrite = '0;
    nreset = 1'b1;
    #2 nreset = 1'b0;
    #1;
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rdata", 32'(rdata), 32'd0);
    chk("reset sram_addr", 32'(sram_addr), 32'd0);
    chk("reset strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    chk("reset be_n", 32'(sram_be_n), 32'd3);
    repeat (2) @(posedge clk);
    @(negedge clk) nreset = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset during a write ACCESS: everything drops at once, no ready later.
    @(posedge clk); #1;
    cs = 1'b1; r = 1'b0; w = 2'b11; addr = 18'h00009; dwrite = 16'h1357;
    seen = 0;
    for (int k = 0; k < 4 && seen == 0; k++) begin
      @(negedge clk);
      if (!sram_we_n) seen = 1;
    end
    chk("rst seq we_n reached", 32'(seen), 32'd1);
    nreset = 1'b0; cs = 1'b0; w = '0;
    #1;
    chk("rst seq strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    chk("rst seq be_n", 32'(sram_be_n), 32'd3);
    chk("rst seq busy", 32'(busy), 32'd0);
    chk("rst seq ready", 32'(ready), 32'd0);
    chk("rst seq dq released", 32'(sram_dq == 16'h1357), 32'd0);
    chk("rst seq rdata", 32'(rdata), 32'd0);
    @(negedge clk) nreset = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready) seen++;
    end
    chk("rst seq no ready", 32'(seen), 32'd0);
    last_rd = 1'b0;

    // cs dropped one cycle after acceptance: the read still completes.
    @(posedge clk); #1;
    cs = 1'b1; r = 1'b1; w = '0; addr = 18'h00123; dwrite = '0;
    @(posedge clk); #1;
    cs = 1'b0; r = 1'b0;
    lat = -1;
    for (int k = 1; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (ready) lat = k;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("cs drop latency", 32'(lat), 32'd5);
    chk("cs drop rdata", 32'(rdata), 32'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
